// File: rtl/extensor_signo_pipe.sv
// Registered immediate generator for decode: valid/ready in, valid/ready out, tag pass-through, flush.
// Define IMM_SKID_EN for a two-entry output stage whose in_ready comes from state only.
module extensor_signo_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      morse,
  input  logic [2:0]       selec,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  salida,
  output logic [TAG_W-1:0] tag_out
);

  function automatic logic [XLEN-1:0] build_imm(input logic [31:0] w, input logic [2:0] sel);
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;
    logic signed [31:0] imm_u;
    logic               unused_opcode;
    logic [XLEN-1:0]    r;
    r             = '0;
    unused_opcode = ^w[6:0];
    imm_i = w[31:20];
    imm_s = {w[31:25], w[11:7]};
    imm_b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    imm_j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    imm_u = {w[31:12], 12'b0};
    // Signed size casts replicate bit 31 of the instruction up to XLEN.
    case (sel)
      3'b000:  r = XLEN'(imm_i);
      3'b001:  r = (XLEN == 64) ? XLEN'(w[25:20]) : XLEN'(w[24:20]);
      3'b010:  r = XLEN'(imm_s);
      3'b011:  r = XLEN'(imm_u);
      3'b100:  r = XLEN'(imm_b);
      3'b101:  r = XLEN'(imm_j);
      3'b110:  r = XLEN'(w[19:15]);
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0]  imm_p0;
  logic             in_xfer;
  logic             out_xfer;
  logic             vld_p1;
  logic [XLEN-1:0]  imm_p1;
  logic [TAG_W-1:0] tag_p1;

  assign imm_p0    = build_imm(morse, selec);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = vld_p1 && out_ready;
  assign out_valid = vld_p1;
  assign salida    = imm_p1;
  assign tag_out   = tag_p1;

  // p0 -> p1: immediate built combinationally, captured at input transfer
`ifdef IMM_SKID_EN
  logic             skid_vld_p1;
  logic [XLEN-1:0]  skid_imm_p1;
  logic [TAG_W-1:0] skid_tag_p1;

  assign in_ready = !skid_vld_p1 && !reset && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      imm_p1      <= '0;
      tag_p1      <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (skid_vld_p1) begin
      // A full skid implies a full output stage; drain it in order.
      if (out_ready) begin
        imm_p1      <= skid_imm_p1;
        tag_p1      <= skid_tag_p1;
        skid_vld_p1 <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!vld_p1 || out_ready) begin
        vld_p1 <= 1'b1;
        imm_p1 <= imm_p0;
        tag_p1 <= tag_in;
      end else begin
        skid_vld_p1 <= 1'b1;
      end
    end else if (out_xfer) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer && vld_p1 && !out_ready) begin
      skid_imm_p1 <= imm_p0;
      skid_tag_p1 <= tag_in;
    end
  end
`else
  assign in_ready = (!vld_p1 || out_ready) && !reset && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      imm_p1 <= '0;
      tag_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_xfer) begin
      vld_p1 <= 1'b1;
      imm_p1 <= imm_p0;
      tag_p1 <= tag_in;
    end else if (out_xfer) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_extensor_signo_pipe.sv
// Self-checking bench for extensor_signo_pipe: XLEN=32 and XLEN=64 instances driven in lockstep.
module tb_extensor_signo_pipe;
  localparam int TAG_W = 8;
`ifdef IMM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, flush, in_valid, out_ready;
  logic [31:0]      morse;
  logic [2:0]       selec;
  logic [TAG_W-1:0] tag_in;
  logic             in_ready, out_valid;
  logic [31:0]      salida;
  logic [TAG_W-1:0] tag_out;
  logic             in_ready64, out_valid64;
  logic [63:0]      salida64;
  logic [TAG_W-1:0] tag_out64;

  extensor_signo_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .morse(morse), .selec(selec), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .salida(salida), .tag_out(tag_out));

  extensor_signo_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .morse(morse), .selec(selec), .tag_in(tag_in), .out_valid(out_valid64),
    .out_ready(out_ready), .salida(salida64), .tag_out(tag_out64));

  typedef struct {
    logic [63:0]      v32;
    logic [63:0]      v64;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference immediate from the format table, using plain integer arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s, input int xlen);
    longint lw, v;
    lw = longint'(w);
    v  = 0;
    case (s)
      3'd0: begin v = lw >> 20; if (w[31]) v = v - 4096; end
      3'd1: v = (lw >> 20) & ((xlen == 64) ? 63 : 31);
      3'd2: begin v = ((lw >> 25) << 5) | ((lw >> 7) & 31); if (w[31]) v = v - 4096; end
      3'd3: begin v = lw & 64'hFFFF_F000; if (w[31]) v = v - 64'h1_0000_0000; end
      3'd4: begin
        v = (((lw >> 31) & 1) << 12) | (((lw >> 7) & 1) << 11) | (((lw >> 25) & 63) << 5) | (((lw >> 8) & 15) << 1);
        if (w[31]) v = v - 8192;
      end
      3'd5: begin
        v = (((lw >> 31) & 1) << 20) | (((lw >> 12) & 255) << 12) | (((lw >> 20) & 1) << 11) | (((lw >> 21) & 1023) << 1);
        if (w[31]) v = v - 2097152;
      end
      3'd6: v = (lw >> 15) & 31;
      default: v = 0;
    endcase
    return (xlen == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  // Advance the model by the transfers visible now, then move to just after the next edge.
  task automatic commit();
    ent_t tmp;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && q.size() > 0) tmp = q.pop_front();
      if (in_valid && in_ready) begin
        tmp.v32 = ref_imm(morse, selec, 32);
        tmp.v64 = ref_imm(morse, selec, 64);
        tmp.tag = tag_in;
        q.push_back(tmp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      commit();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (salida !== 32'h0 || salida64 !== 64'h0) begin
      errors++; $display("FAIL reset_salida: got %h/%h want 0", salida, salida64);
    end
    checks++;
    if (tag_out !== 8'h0) begin errors++; $display("FAIL reset_tag: got %h want 00", tag_out); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    commit();
  endtask

  task automatic test_formats();
    logic [31:0] words [10];
    logic [2:0]  sels  [10];
    logic [31:0] exp32 [10];
    logic [63:0] exp64 [10];
    words = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h340FD073, 32'h12345037,
              32'hDEADBEEF, 32'h03F09093, 32'h80000037, 32'hFE112E23, 32'h00500093};
    sels  = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b011, 3'b111, 3'b001, 3'b011, 3'b010, 3'b000};
    exp32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h0000001F, 32'h12345000,
              32'h00000000, 32'h0000001F, 32'h80000000, 32'hFFFFFFFC, 32'h00000005};
    exp64 = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'h8, 64'h1F, 64'h12345000,
              64'h0, 64'h3F, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFFC, 64'h5};
    for (int i = 0; i < 10; i++) begin
      morse = words[i]; selec = sels[i]; tag_in = 8'(16 + i);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL fmt_in_ready[%0d]: got %b want 1", i, in_ready); end
      commit();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || salida !== exp32[i] || tag_out !== 8'(16 + i)) begin
        errors++;
        $display("FAIL fmt32[%0d]: got v=%b %h tag %h want v=1 %h tag %h", i, out_valid, salida, tag_out, exp32[i], 8'(16 + i));
      end
      checks++;
      if (out_valid64 !== 1'b1 || salida64 !== exp64[i] || tag_out64 !== 8'(16 + i)) begin
        errors++;
        $display("FAIL fmt64[%0d]: got v=%b %h tag %h want v=1 %h tag %h", i, out_valid64, salida64, tag_out64, exp64[i], 8'(16 + i));
      end
      commit();
    end
  endtask

  task automatic test_back_pressure();
    int               sent = 0;
    int               got  = 0;
    int               cyc  = 0;
    logic             hold = 1'b0;
    logic [31:0]      hs = '0;
    logic [63:0]      hs64 = '0;
    logic [TAG_W-1:0] ht = '0;
    while (got < 8 && cyc < 300) begin
      morse = $urandom; selec = 3'($urandom_range(0, 7)); tag_in = 8'(sent);
      in_valid  = (sent < 8) && ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (out_valid !== (q.size() != 0) || out_valid64 !== out_valid) begin
        errors++; $display("FAIL bp_out_valid: got %b/%b want %b", out_valid, out_valid64, q.size() != 0);
      end
      checks++;
      if (in_ready && q.size() >= CAP && !(CAP == 1 && out_ready)) begin
        errors++; $display("FAIL bp_in_ready_full: got in_ready=1 occupancy %0d want in_ready=0", q.size());
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || salida !== hs || salida64 !== hs64 || tag_out !== ht) begin
          errors++; $display("FAIL bp_stable: got v=%b %h tag %h want v=1 %h tag %h", out_valid, salida, tag_out, hs, ht);
        end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        checks++;
        if (tag_out !== 8'(got)) begin errors++; $display("FAIL bp_order: got tag %h want %h", tag_out, 8'(got)); end
        checks++;
        if ({32'h0, salida} !== q[0].v32 || salida64 !== q[0].v64) begin
          errors++; $display("FAIL bp_value: got %h/%h want %h/%h", salida, salida64, q[0].v32, q[0].v64);
        end
        got++;
      end
      hold = out_valid && !out_ready; hs = salida; hs64 = salida64; ht = tag_out;
      if (in_valid && in_ready) sent++;
      cyc++;
      commit();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8) begin errors++; $display("FAIL bp_count: got %0d outputs want 8 (cycle budget)", got); end
  endtask

  task automatic test_flush();
    logic full = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      morse = $urandom; selec = 3'($urandom_range(0, 7)); tag_in = 8'(8'h40 + i);
      @(negedge clk);
      full = !in_ready;
      commit();
      if (full) break;
    end
    checks++;
    if (!full || q.size() != CAP) begin
      errors++; $display("FAIL flush_fill: got full=%b occupancy %0d want full=1 occupancy %0d", full, q.size(), CAP);
    end
    flush = 1'b1; in_valid = 1'b1; morse = 32'hFFF00093; selec = 3'b000; tag_in = 8'hAA;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    commit();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_after: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    commit();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_valid64 !== 1'b0) begin
        errors++; $display("FAIL flush_ghost: got out_valid=%b tag %h want 0", out_valid, tag_out);
      end
      commit();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; morse = $urandom; selec = 3'b000; tag_in = 8'h5A;
    @(negedge clk);
    commit();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b want 1", out_valid); end
    commit();
    reset = 1'b1; in_valid = 1'b1; tag_in = 8'hBB;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready: got %b want 0", in_ready); end
    commit();
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; morse = 32'h12345037; selec = 3'b011; tag_in = 8'h5C;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || salida !== 32'h0 || tag_out !== 8'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rm_after: got v=%b %h tag %h rdy %b want v=0 0 tag 00 rdy 1", out_valid, salida, tag_out, in_ready);
    end
    commit();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || salida !== 32'h12345000 || tag_out !== 8'h5C) begin
      errors++; $display("FAIL rm_first: got v=%b %h tag %h want v=1 12345000 tag 5c", out_valid, salida, tag_out);
    end
    commit();
  endtask

  task automatic test_back_to_back();
    int outs = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16); morse = $urandom; selec = 3'($urandom_range(0, 7)); tag_in = 8'(8'h20 + i);
      @(negedge clk);
      if (i < 16) begin
        checks++;
        if (in_ready !== 1'b1 || in_ready64 !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready[%0d]: got %b/%b want 1", i, in_ready, in_ready64);
        end
      end
      if (i >= 1 && i <= 16) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid[%0d]: got %b want 1", i, out_valid); end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        checks++;
        if (tag_out !== 8'(8'h20 + outs) || {32'h0, salida} !== q[0].v32 || salida64 !== q[0].v64) begin
          errors++;
          $display("FAIL b2b_value[%0d]: got tag %h %h/%h want tag %h %h/%h", outs, tag_out, salida, salida64,
                   8'(8'h20 + outs), q[0].v32, q[0].v64);
        end
        outs++;
      end
      commit();
    end
    checks++;
    if (outs != 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", outs); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    morse = '0; selec = '0; tag_in = '0;
    test_reset();
    test_formats();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
